// File: rtl/sme_load_driver.sv
`default_nettype none
// ============================================================================
// Module      : sme_load_driver
// Description : Serialises a host string/pattern request into one gap-free
//               byte write burst to the SME shared memory, then waits for
//               mem_valid. Optional watchdog: define SME_LOAD_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module sme_load_driver #(
    parameter int BYTE        = 8,
    parameter int MAX_STRING  = 32,
    parameter int MAX_PATTERN = 8,
    parameter int STR_LW      = 6,
    parameter int PAT_LW      = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [MAX_STRING*BYTE-1:0]    str_buf,
    input  logic [MAX_PATTERN*BYTE-1:0]   pat_buf,
    input  logic [STR_LW-1:0]             str_len,
    input  logic [PAT_LW-1:0]             pat_len,
    input  logic                          mem_valid,
    output logic [BYTE-1:0]               w_data,
    output logic                          write,
    output logic                          w_sel,
    output logic                          busy,
    output logic                          done,
    output logic                          err,
    output logic                          timeout
);

    localparam int c_SIW = (MAX_STRING  > 1) ? $clog2(MAX_STRING)  : 1;
    localparam int c_PIW = (MAX_PATTERN > 1) ? $clog2(MAX_PATTERN) : 1;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_SEND_STR   = 3'd1,
        S_SEND_PAT   = 3'd2,
        S_WAIT_VALID = 3'd3,
        S_FINISH     = 3'd4
    } state_t;

    state_t            r_state;
    logic [STR_LW-1:0] r_idx;
    logic [STR_LW-1:0] r_str_len;
    logic [PAT_LW-1:0] r_pat_len;
    logic              r_wait_first;
    logic [BYTE-1:0]   r_w_data;
    logic              r_write;
    logic              r_w_sel;
    logic              r_busy;
    logic              r_done;
    logic              r_err;
    logic              w_req_ok;

    logic [BYTE-1:0] w_str_byte [MAX_STRING];
    logic [BYTE-1:0] w_pat_byte [MAX_PATTERN];

    for (genvar k = 0; k < MAX_STRING; k++) begin : g_str_unpack
        assign w_str_byte[k] = str_buf[k*BYTE +: BYTE];
    end

    for (genvar k = 0; k < MAX_PATTERN; k++) begin : g_pat_unpack
        assign w_pat_byte[k] = pat_buf[k*BYTE +: BYTE];
    end

    assign w_req_ok = (str_len != '0) && (32'(str_len) <= MAX_STRING) &&
                      (pat_len != '0) && (32'(pat_len) <= MAX_PATTERN);

`ifdef SME_LOAD_TIMEOUT_EN
    localparam int c_TCW = $clog2(TIMEOUT_CYC + 1);
    logic [c_TCW-1:0] r_to_cnt;
    logic             r_timeout;
    assign timeout = r_timeout;
`else
    // No watchdog in this build; TIMEOUT_CYC is positive so this is constant low.
    assign timeout = (TIMEOUT_CYC < 0);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_idx        <= '0;
            r_str_len    <= '0;
            r_pat_len    <= '0;
            r_wait_first <= 1'b0;
            r_w_data     <= '0;
            r_write      <= 1'b0;
            r_w_sel      <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
`ifdef SME_LOAD_TIMEOUT_EN
            r_to_cnt     <= '0;
            r_timeout    <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
`ifdef SME_LOAD_TIMEOUT_EN
            r_timeout <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_str_len <= str_len;
                        r_pat_len <= pat_len;
                        if (!w_req_ok) begin
                            r_err <= 1'b1;
                        end else begin
                            // Beat 0 is launched here so the burst starts right after start.
                            r_state  <= S_SEND_STR;
                            r_busy   <= 1'b1;
                            r_write  <= 1'b1;
                            r_w_sel  <= 1'b0;
                            r_w_data <= w_str_byte[0];
                            r_idx    <= STR_LW'(1);
                        end
                    end
                end

                S_SEND_STR: begin
                    if (r_idx == r_str_len) begin
                        r_state  <= S_SEND_PAT;
                        r_w_sel  <= 1'b1;
                        r_w_data <= w_pat_byte[0];
                        r_idx    <= STR_LW'(1);
                    end else begin
                        r_w_data <= w_str_byte[r_idx[c_SIW-1:0]];
                        r_idx    <= r_idx + 1'b1;
                    end
                end

                S_SEND_PAT: begin
                    if (r_idx == STR_LW'(r_pat_len)) begin
                        r_state      <= S_WAIT_VALID;
                        r_write      <= 1'b0;
                        r_w_sel      <= 1'b0;
                        r_w_data     <= '0;
                        r_idx        <= '0;
                        r_wait_first <= 1'b1;
                    end else begin
                        r_w_data <= w_pat_byte[r_idx[c_PIW-1:0]];
                        r_idx    <= r_idx + 1'b1;
                    end
                end

                S_WAIT_VALID: begin
                    // The first cycle may still see the previous transaction's level.
                    r_wait_first <= 1'b0;
                    if (!r_wait_first && mem_valid) begin
                        r_state <= S_FINISH;
                        r_done  <= 1'b1;
`ifdef SME_LOAD_TIMEOUT_EN
                        r_to_cnt <= '0;
                    end else if (r_to_cnt == c_TCW'(TIMEOUT_CYC - 1)) begin
                        r_state   <= S_IDLE;
                        r_busy    <= 1'b0;
                        r_err     <= 1'b1;
                        r_timeout <= 1'b1;
                        r_to_cnt  <= '0;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
`endif
                    end
                end

                S_FINISH: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end

                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_write <= 1'b0;
                end
            endcase
        end
    end

    assign w_data = r_w_data;
    assign write  = r_write;
    assign w_sel  = r_w_sel;
    assign busy   = r_busy;
    assign done   = r_done;
    assign err    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_sme_load_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_sme_load_driver
// Description : Directed self-checking bench for sme_load_driver.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sme_load_driver;

    localparam int BYTE        = 8;
    localparam int MAX_STRING  = 32;
    localparam int MAX_PATTERN = 8;
    localparam int STR_LW      = 6;
    localparam int PAT_LW      = 4;
    localparam int TO_CYC      = 16;

    logic                        clk;
    logic                        reset;
    logic                        start;
    logic [MAX_STRING*BYTE-1:0]  str_buf;
    logic [MAX_PATTERN*BYTE-1:0] pat_buf;
    logic [STR_LW-1:0]           str_len;
    logic [PAT_LW-1:0]           pat_len;
    logic                        mem_valid;
    logic [BYTE-1:0]             w_data;
    logic                        write;
    logic                        w_sel;
    logic                        busy;
    logic                        done;
    logic                        err;
    logic                        timeout;

    int n_checks = 0;
    int n_fail   = 0;

    sme_load_driver #(
        .BYTE        (BYTE),
        .MAX_STRING  (MAX_STRING),
        .MAX_PATTERN (MAX_PATTERN),
        .STR_LW      (STR_LW),
        .PAT_LW      (PAT_LW),
        .TIMEOUT_CYC (TO_CYC)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .str_buf   (str_buf),
        .pat_buf   (pat_buf),
        .str_len   (str_len),
        .pat_len   (pat_len),
        .mem_valid (mem_valid),
        .w_data    (w_data),
        .write     (write),
        .w_sel     (w_sel),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch a request and check every beat against the bench's own buffers.
    task automatic run_burst(input int slen, input int plen, input int pulse_beat);
        logic [7:0] exp_d;
        str_len = 6'(slen);
        pat_len = 4'(plen);
        start   = 1'b1;
        tick();
        start   = 1'b0;
        for (int k = 0; k < slen + plen; k++) begin
            exp_d = (k < slen) ? str_buf[k*BYTE +: BYTE] : pat_buf[(k-slen)*BYTE +: BYTE];
            check_eq("burst_write", write, 1'b1);
            check_eq("burst_sel", w_sel, (k >= slen) ? 1'b1 : 1'b0);
            check_eq("burst_data", w_data, exp_d);
            check_eq("burst_busy", busy, 1'b1);
            if (k == pulse_beat) start = 1'b1;
            tick();
            start = 1'b0;
        end
        check_eq("post_burst_write", write, 1'b0);
        check_eq("post_burst_data", w_data, 8'h00);
        check_eq("post_burst_busy", busy, 1'b1);
    endtask

    // Wait delay cycles in WAIT_VALID, raise mem_valid once, expect a single done.
    task automatic wait_done(input int delay);
        for (int i = 0; i < delay; i++) begin
            check_eq("wait_write", write, 1'b0);
            check_eq("wait_done_low", done, 1'b0);
            check_eq("wait_busy", busy, 1'b1);
            tick();
        end
        mem_valid = 1'b1;
        tick();
        check_eq("done_pulse", done, 1'b1);
        check_eq("done_busy", busy, 1'b1);
        mem_valid = 1'b0;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        check_eq("done_cleared", done, 1'b0);
        check_eq("idle_busy", busy, 1'b0);
        check_eq("finish_start_ignored", write, 1'b0);
        tick();
        check_eq("idle_write", write, 1'b0);
        check_eq("idle_busy2", busy, 1'b0);
        check_eq("idle_done", done, 1'b0);
    endtask

    task automatic reject(input int slen, input int plen);
        str_len = 6'(slen);
        pat_len = 4'(plen);
        start   = 1'b1;
        tick();
        start   = 1'b0;
        check_eq("reject_err", err, 1'b1);
        check_eq("reject_write", write, 1'b0);
        check_eq("reject_busy", busy, 1'b0);
        tick();
        check_eq("reject_err_clr", err, 1'b0);
        check_eq("reject_write2", write, 1'b0);
        check_eq("reject_busy2", busy, 1'b0);
    endtask

    logic [7:0] t1_data [6];
    logic       t1_sel  [6];

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        str_buf   = '0;
        pat_buf   = '0;
        str_len   = '0;
        pat_len   = '0;
        mem_valid = 1'b0;
        t1_data   = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h42, 8'h43};
        t1_sel    = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

        tick();
        tick();
        check_eq("rst_write", write, 1'b0);
        check_eq("rst_data", w_data, 8'h00);
        check_eq("rst_sel", w_sel, 1'b0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_done", done, 1'b0);
        check_eq("rst_err", err, 1'b0);
        check_eq("rst_timeout", timeout, 1'b0);
        reset = 1'b0;
        tick();

        // "ABCD" then "BC": hand-computed beat table.
        str_buf[31:0] = 32'h4443_4241;
        pat_buf[15:0] = 16'h4342;
        str_len = 6'd4;
        pat_len = 4'd2;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        for (int k = 0; k < 6; k++) begin
            check_eq("t1_write", write, 1'b1);
            check_eq("t1_data", w_data, t1_data[k]);
            check_eq("t1_sel", w_sel, t1_sel[k]);
            tick();
        end
        check_eq("t1_write_end", write, 1'b0);
        wait_done(5);

        reject(0, 3);
        reject(4, 9);
        reject(33, 2);

        // Maximum lengths with a stray start in the middle of the burst.
        for (int k = 0; k < MAX_STRING; k++) str_buf[k*BYTE +: BYTE] = 8'(8'h80 + k);
        for (int k = 0; k < MAX_PATTERN; k++) pat_buf[k*BYTE +: BYTE] = 8'(8'hC0 + k);
        run_burst(MAX_STRING, MAX_PATTERN, 10);
        wait_done(2);

        // Stale mem_valid held across the whole next request.
        mem_valid = 1'b1;
        tick();
        tick();
        check_eq("stale_idle_done", done, 1'b0);
        run_burst(2, 1, -1);
        tick();
        check_eq("stale_first_wait_done", done, 1'b0);
        check_eq("stale_first_wait_busy", busy, 1'b1);
        mem_valid = 1'b0;
        wait_done(3);

        // Reset while string beat 3 is on the bus.
        str_len = 6'd8;
        pat_len = 4'd2;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        tick();
        tick();
        tick();
        check_eq("rst_mid_beat3_write", write, 1'b1);
        check_eq("rst_mid_beat3_data", w_data, 8'h83);
        reset = 1'b1;
        tick();
        check_eq("rst_mid_write", write, 1'b0);
        check_eq("rst_mid_busy", busy, 1'b0);
        check_eq("rst_mid_data", w_data, 8'h00);
        reset = 1'b0;
        tick();
        check_eq("rst_mid_idle_write", write, 1'b0);
        run_burst(4, 2, -1);
        wait_done(1);

`ifdef SME_LOAD_TIMEOUT_EN
        run_burst(3, 2, -1);
        for (int i = 0; i < TO_CYC - 1; i++) begin
            check_eq("to_wait_timeout", timeout, 1'b0);
            check_eq("to_wait_busy", busy, 1'b1);
            tick();
        end
        tick();
        check_eq("to_timeout", timeout, 1'b1);
        check_eq("to_err", err, 1'b1);
        check_eq("to_done", done, 1'b0);
        check_eq("to_busy", busy, 1'b0);
        tick();
        check_eq("to_timeout_clr", timeout, 1'b0);
        check_eq("to_err_clr", err, 1'b0);
        check_eq("to_done_after", done, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sme_load_driver.md
Name: sme_load_driver

Overview:
- Transmit end of the SME shared-memory byte write interface.
- Takes a host request holding a packed string buffer, a packed pattern buffer and their lengths. Serialises them as one contiguous write burst on w_data/write/w_sel: string bytes first, then pattern bytes.
- After the burst, releases write and waits for the memory's mem_valid (failure function ready), then reports done.
- Sits between the host/testbench command source and the shared memory.

Parameters:
- BYTE, 8, bits per character
- MAX_STRING, 32, max string bytes
- MAX_PATTERN, 8, max pattern bytes
- STR_LW, 6, width of str_len (holds 0..MAX_STRING)
- PAT_LW, 4, width of pat_len (holds 0..MAX_PATTERN)
- TIMEOUT_CYC, 1024, mem_valid wait limit (used only with SME_LOAD_TIMEOUT_EN)

Ports:
- clk  input  1  clock
- reset  input  1  reset, synchronous, active-high
- start  input  1  request pulse/level, sampled in IDLE
- str_buf  input  MAX_STRING*BYTE  string bytes; byte k at [k*BYTE +: BYTE]
- pat_buf  input  MAX_PATTERN*BYTE  pattern bytes, same packing
- str_len  input  STR_LW  string byte count
- pat_len  input  PAT_LW  pattern byte count
- mem_valid  input  1  shared-memory result-valid (level)
- w_data  output  BYTE  byte to memory
- write  output  1  write strobe to memory
- w_sel  output  1  0 = string register, 1 = pattern register
- busy  output  1  high outside IDLE
- done  output  1  one-cycle pulse, transfer and fail-function complete
- err  output  1  one-cycle pulse, request rejected or timed out
- timeout  output  1  one-cycle pulse on watchdog expiry (tied 0 without the macro)

Behaviour:
- All outputs registered. Reset (synchronous) takes effect at the clock edge: state IDLE, write=0, w_sel=0, w_data=0, busy=0, done=0, err=0, timeout=0, counters 0.
- States: IDLE, SEND_STR, SEND_PAT, WAIT_VALID, FINISH.
- IDLE, start=1:
  - str_len and pat_len are latched.
  - If str_len==0, str_len>MAX_STRING, pat_len==0 or pat_len>MAX_PATTERN: err=1 for the next cycle, no write, stay IDLE.
  - Otherwise go to SEND_STR. The first write beat appears on the cycle after start is sampled.
- SEND_STR:
  - Each cycle: write=1, w_sel=0, w_data=str_buf byte idx; idx increments.
  - After beat str_len-1, go to SEND_PAT with idx=0.
- SEND_PAT:
  - Each cycle: write=1, w_sel=1, w_data=pat_buf byte idx.
  - After beat pat_len-1, go to WAIT_VALID.
- Burst shape:
  - write stays high with no gap for exactly str_len+pat_len consecutive cycles.
  - The memory treats a write=0 cycle as end of load, so no bubbles are permitted.
- WAIT_VALID:
  - write=0, w_data=0, w_sel=0.
  - mem_valid is ignored on the first WAIT_VALID cycle, because a stale level from the prior transaction has not yet cleared.
  - On mem_valid=1 thereafter, go to FINISH.
- FINISH: done=1 for one cycle, then IDLE.
- busy=1 in every non-IDLE state.
- start while busy is ignored; it is not queued.
- str_buf and pat_buf are not latched. The host holds them stable while busy.
- start asserted in the same cycle done pulses is ignored. A new request needs start in an IDLE cycle.
- Reset mid-burst: write drops to 0 at the reset edge and partial state is discarded. The shared memory is reset with the same signal.

Optional Feature:
- Macro SME_LOAD_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT_VALID.
  - If mem_valid has not arrived after TIMEOUT_CYC cycles, timeout=1 and err=1 for one cycle, no done pulse, return to IDLE.
  - The counter clears on leaving WAIT_VALID.
- Undefined: WAIT_VALID waits indefinitely; timeout is constant 0.

Test Plan:
- str "ABCD" (len 4), pat "BC" (len 2), start 1 cycle -> 6 consecutive write cycles: w_data 41,42,43,44,42,43 (hex), w_sel 0,0,0,0,1,1. Then write=0; mem_valid raised 5 cycles later -> done pulses exactly once, one cycle after; busy low thereafter.
- str_len=0, pat_len=3 -> err pulse the cycle after start, write never asserts, busy stays 0. Same with pat_len=9.
- Max lengths 32/8 -> 40 unbroken write cycles, last pattern byte from pat_buf[63:56]. start pulsed at cycle 10 of the burst -> no effect.
- mem_valid held high from the previous transaction into the new request -> not acted on until after the burst plus one WAIT_VALID cycle; done only after a fresh mem_valid.
- Reset asserted on beat 3 of the string -> write=0 and busy=0 from the reset edge. A following clean request completes normally.
- With SME_LOAD_TIMEOUT_EN, TIMEOUT_CYC=16, mem_valid never asserted -> timeout and err pulse together 16 cycles into WAIT_VALID, no done, back to IDLE.
